// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM-stage load/store logic and data_memory.
// Drains one store per cycle, forwards loads from the youngest matching entry.
module store_buffer #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_fwd,
    input  logic                     drain_hold,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    output logic                     mem_write,
    output logic                     mem_read,
    input  logic [DATA_W-1:0]        mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]  entry_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              push;
    logic              drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  scan_idx;
    logic              ld_miss;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign count    = count_q;
    assign push     = st_valid && !full;

    // Walk entries oldest to youngest so the last match found is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (entry_valid[scan_idx] && (entry_addr[scan_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[scan_idx];
            end
        end
    end

    assign ld_miss = ld_req && !fwd_hit;
    assign drain   = !ld_miss && !empty && !drain_hold;
    assign ld_fwd  = ld_req && fwd_hit;
    assign ld_data = fwd_hit ? fwd_data : mem_read_data;

    // A load miss owns the single memory port; otherwise the head store drains.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (ld_miss) begin
            mem_read    = 1'b1;
            mem_address = ld_addr;
        end else if (drain) begin
            mem_write      = rst_n;
            mem_address    = entry_addr[head];
            mem_write_data = entry_data[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                tail                <= tail + 1'b1;
                entry_valid[tail]   <= 1'b1;
            end
            if (drain) begin
                head                <= head + 1'b1;
                entry_valid[head]   <= 1'b0;
            end
            case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail] <= st_addr;
            entry_data[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and a model of data_memory.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [23:0] st_addr;
    logic [23:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [23:0] ld_addr;
    logic [23:0] ld_data;
    logic        ld_fwd;
    logic        drain_hold;
    logic        empty;
    logic [2:0]  count;
    logic [23:0] mem_address;
    logic [23:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [23:0] mem_read_data;

    typedef struct packed {
        logic [23:0] addr;
        logic [23:0] data;
    } store_t;

    store_t      sbq[$];
    logic [23:0] refMem [1024];
    logic [23:0] mem [1024];
    int          checks = 0;
    int          failures = 0;
    bit          modelPop;
    bit          modelCanPush;

    store_buffer #(.DATA_W(24), .ADDR_W(24), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_fwd(ld_fwd),
        .drain_hold(drain_hold), .empty(empty), .count(count),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[9:0]];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the queue model for the current inputs
    task automatic checkOutput();
        bit          hit = 1'b0;
        logic [23:0] fdata = '0;
        bit          miss;
        bit          wr;
        logic [23:0] expAddr;
        for (int i = 0; i < sbq.size(); i++) begin
            if (ld_req && sbq[i].addr == ld_addr) begin
                hit   = 1'b1;
                fdata = sbq[i].data;
            end
        end
        miss    = ld_req && !hit;
        wr      = !miss && sbq.size() > 0 && !drain_hold;
        expAddr = miss ? ld_addr : (wr ? sbq[0].addr : 24'h0);
        checkVal("count", 32'(count), 32'(sbq.size()));
        checkVal("empty", 32'(empty), 32'(sbq.size() == 0));
        checkVal("st_ready", 32'(st_ready), 32'(sbq.size() < DEPTH));
        checkVal("mem_read", 32'(mem_read), 32'(miss));
        checkVal("mem_write", 32'(mem_write), 32'(wr));
        checkVal("mem_address", 32'(mem_address), 32'(expAddr));
        if (wr) checkVal("mem_write_data", 32'(mem_write_data), 32'(sbq[0].data));
        if (ld_req) begin
            checkVal("ld_fwd", 32'(ld_fwd), 32'(hit));
            checkVal("ld_data", 32'(ld_data), 32'(hit ? fdata : refMem[ld_addr[9:0]]));
        end
        modelPop     = wr;
        modelCanPush = sbq.size() < DEPTH;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance model
    task automatic applyStimulus(input bit sv, input logic [23:0] sa, input logic [23:0] sd,
                                 input bit lr, input logic [23:0] la, input bit hold);
        store_t s;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_req = lr; ld_addr = la; drain_hold = hold;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        if (modelPop) begin
            refMem[sbq[0].addr[9:0]] = sbq[0].data;
            void'(sbq.pop_front());
        end
        if (sv && modelCanPush) begin
            s.addr = sa;
            s.data = sd;
            sbq.push_back(s);
        end
        #1;
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] d;
        int          op;
        bit          h;
        int          budget;

        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 24'(i);
            refMem[i] = 24'(i);
        end

        // Reset: mem_write held low even with a store offered
        rst_n = 1'b0; st_valid = 1'b1; st_addr = 24'h040; st_data = 24'h123456;
        ld_req = 1'b0; ld_addr = '0; drain_hold = 1'b0;
        #2;
        checkOutput();
        @(posedge clk); #1;
        checkOutput();
        st_valid = 1'b0;
        rst_n = 1'b1;

        // Single store then drain
        applyStimulus(1, 24'h010, 24'hABCDEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Fill under hold, drop fifth store, release
        for (int i = 0; i < 5; i++) applyStimulus(1, 24'h030 + 24'(i), 24'h500 + 24'(i), 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Youngest-match forwarding, then a miss that stalls drain
        applyStimulus(1, 24'h020, 24'h000001, 0, 0, 1);
        applyStimulus(1, 24'h020, 24'h000002, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 24'h020, 1);
        applyStimulus(0, 0, 0, 1, 24'h005, 0);
        applyStimulus(0, 0, 0, 1, 24'h020, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Full-rate stores with hold toggling to wrap the pointers
        for (int i = 0; i < 10; i++) applyStimulus(1, 24'h060 + 24'(i % 3), $urandom, 0, 0, i[0]);

        // Randomized mix of stores, loads and idles
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 2);
            h  = ($urandom_range(0, 3) == 0);
            a  = 24'h100 + 24'($urandom_range(0, 7));
            d  = 24'($urandom);
            if (op == 0)      applyStimulus(1, a, d, 0, 0, h);
            else if (op == 1) applyStimulus(0, 0, 0, 1, ($urandom_range(0, 1) == 0) ? a : 24'($urandom_range(0, 1023)), h);
            else              applyStimulus(0, 0, 0, 0, 0, h);
        end
        budget = 0;
        while (sbq.size() > 0 && budget < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            budget++;
        end
        checkVal("drain_done", 32'(empty), 32'd1);

        // Reset mid-drain with three pending stores
        for (int i = 0; i < 3; i++) applyStimulus(1, 24'h200 + 24'(i), 24'hCC0000 + 24'(i), 0, 0, 1);
        st_valid = 1'b0; ld_req = 1'b0; drain_hold = 1'b0;
        @(negedge clk);
        checkOutput();
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        checkVal("rst_count", 32'(count), 32'd0);
        checkVal("rst_mem_write", 32'(mem_write), 32'd0);
        checkVal("rst_empty", 32'(empty), 32'd1);
        @(posedge clk); #1;
        checkVal("rst_hold_mem_write", 32'(mem_write), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Final memory image against the reference
        for (int i = 0; i < 1024; i++) checkVal("mem_image", 32'(mem[i]), 32'(refMem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
